// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Bundles the E-stage request and the HI/LO/busy response of the multiply/
// divide unit.
//   start  : E-stage instruction is an MD-class op this cycle
//   flush  : exception/eret in M stage, suppresses start this cycle
//   md_op  : operation code (NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MADD/MADDU)
//   src_a  : rs operand, already forwarded
//   src_b  : rt operand, already forwarded
//   busy   : multi-cycle operation in progress
//   hi, lo : architectural HI/LO registers
// Modports: master = pipeline side, slave = multiply/divide unit.
// -----------------------------------------------------------------------------
interface mult_div_unit_if;
  logic        start;
  logic        flush;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, flush, md_op, src_a, src_b,
                  input  busy, hi, lo);
  modport slave  (input  start, flush, md_op, src_a, src_b,
                  output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// E-stage multiply/divide unit owning the HI/LO registers. Results are computed
// at acceptance and held in pending registers; busy is raised for a fixed
// MULT_CYCLES / DIV_CYCLES so the stall controller can hold HI/LO consumers,
// and HI/LO update on the edge that drops busy. MTHI/MTLO write immediately.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : mult_div_unit_if.slave (start/flush/md_op/src_a/src_b in,
//           busy/hi/lo out)
// Optional build macro: MDU_MADD_EN adds MADD (7) / MADDU (8) accumulate into
// {hi,lo}; when undefined those codes behave as NONE and no adder is built.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;

  logic is_mul, is_div, is_mthi, is_mtlo, signed_op, accept;
`ifdef MDU_MADD_EN
  logic is_madd;
`endif

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    signed_op = 1'b0;
`ifdef MDU_MADD_EN
    is_madd   = 1'b0;
`endif
    case (bus.md_op)
      OP_MULT:  begin is_mul = 1'b1; signed_op = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; signed_op = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      OP_MTHI:  is_mthi = 1'b1;
      OP_MTLO:  is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; is_madd = 1'b1; signed_op = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_madd = 1'b1; end
`endif
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arithmetic. One 64x64 multiplier serves both signednesses: the operands are
  // sign- or zero-extended to 64 bits and the low 64 product bits are exact.
  // ---------------------------------------------------------------------------
  logic [63:0] a_ext, b_ext, prod, mul_res;
  logic [31:0] divisor, quot, rem;
  logic        div_zero;

  always_comb begin
    a_ext = signed_op ? {{32{bus.src_a[31]}}, bus.src_a} : {32'b0, bus.src_a};
    b_ext = signed_op ? {{32{bus.src_b[31]}}, bus.src_b} : {32'b0, bus.src_b};
    prod  = a_ext * b_ext;
`ifdef MDU_MADD_EN
    mul_res = is_madd ? ({hi_q, lo_q} + prod) : prod;
`else
    mul_res = prod;
`endif
  end

  // A zero divisor is replaced by 1 purely to keep the divider output defined;
  // the result is never written because pend_wr is cleared for that case.
  always_comb begin
    div_zero = (bus.src_b == 32'd0);
    divisor  = div_zero ? 32'd1 : bus.src_b;
    if (!signed_op) begin
      quot = bus.src_a / divisor;
      rem  = bus.src_a % divisor;
    end else if (bus.src_a == 32'h8000_0000 && bus.src_b == 32'hFFFF_FFFF) begin
      // The only signed overflow: the true quotient 2^31 wraps to itself.
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end else begin
      quot = $signed(bus.src_a) / $signed(divisor);
      rem  = $signed(bus.src_a) % $signed(divisor);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  assign accept = bus.start && !bus.flush && (state == IDLE) &&
                  (is_mul || is_div || is_mthi || is_mtlo);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept && (is_mul || is_div)) state_n = RUN;
      RUN:  if (cnt == CNT_ONE)               state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counter, pending result, HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        pend_hi <= mul_res[63:32];
        pend_lo <= mul_res[31:0];
        pend_wr <= 1'b1;
        cnt     <= MULT_LOAD;
      end else if (is_div) begin
        pend_hi <= rem;
        pend_lo <= quot;
        pend_wr <= !div_zero;
        cnt     <= DIV_LOAD;
      end else if (is_mthi) begin
        hi_q <= bus.src_a;
      end else begin
        lo_q <= bus.src_a;
      end
    end else if (state == RUN) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE && pend_wr) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
